// File: rtl/sram_fifo_pkg.sv
// Shared definitions for the SRAM-backed FIFO controller: default widths,
// occupancy counter width and the read-sequencing state encoding.
package sram_fifo_pkg;

  localparam int unsigned DW_DEFAULT = 4;
  localparam int unsigned AW_DEFAULT = 2;
  localparam int unsigned CNT_W      = AW_DEFAULT + 1;

  // IDLE: no read outstanding; RD_WAIT: sram_rdata valid this cycle
  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/sram_fifo_ctrl_if.sv
// Write/read stream bundle for sram_fifo_ctrl.
//   in_valid/in_data/in_ready    : producer -> FIFO write stream
//   out_valid/out_data/out_ready : FIFO -> consumer read stream
// master = producer/consumer side, slave = FIFO controller side.
interface sram_fifo_ctrl_if
  import sram_fifo_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
);

  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/sram.sv
// 4x4 single-port synchronous SRAM. One op per cycle: we=1 writes data_in
// to addr; we=0 reads addr into data_out, which is valid the next cycle.
//   clk, addr[AW], we, data_in[DW] -> data_out[DW]
module sram #(
  parameter int unsigned DW = 4,
  parameter int unsigned AW = 2
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= data_in;
    end else begin
      data_out <= mem[addr];
    end
  end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// Single-port FIFO controller sitting in front of a DEPTH-entry synchronous
// SRAM, plus a one-entry output register (DEPTH+1 words total).
// Ports:
//   clk, rst_n            clock, async active-low reset
//   io (slave)            in_valid/in_data/in_ready write stream,
//                         out_valid/out_data/out_ready read stream
//   count, full, empty    occupancy (SRAM + in-flight read + output slot)
//   sram_addr/we/wdata    drive the SRAM; sram_rdata comes back from it
//   peak                  high-water mark of count (only when
//                         SRAM_FIFO_WMARK_EN is defined)
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT,
  parameter int unsigned AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  sram_fifo_ctrl_if.slave io,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic [AW-1:0] sram_addr,
  output logic          sram_we,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata
`ifdef SRAM_FIFO_WMARK_EN
  ,
  output logic [AW:0]   peak
`endif
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = AW + 1;

  state_t        state_q;
  state_t        state_d;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] stor_cnt_q;
  logic          out_valid_q;
  logic [DW-1:0] out_data_q;
  logic          rd_go;
  logic          wr_go;
  logic          in_ready_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a read always takes exactly one wait cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rd_go) state_d = RD_WAIT;
      RD_WAIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: read issue wins over write; SRAM sees a single op per cycle
  always_comb begin
    rd_go      = 1'b0;
    in_ready_c = 1'b0;
    wr_go      = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = rd_ptr_q;
    sram_wdata = io.in_data;
    rd_go      = (state_q == IDLE) && (stor_cnt_q != '0) && !out_valid_q;
    in_ready_c = !full && !rd_go;
    wr_go      = io.in_valid && in_ready_c;
    if (wr_go) begin
      sram_we   = 1'b1;
      sram_addr = wr_ptr_q;
    end
  end

  // Pointers and SRAM occupancy; wr_go and rd_go are mutually exclusive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      stor_cnt_q <= '0;
    end else begin
      if (wr_go) begin
        wr_ptr_q   <= wr_ptr_q + AW'(1);
        stor_cnt_q <= stor_cnt_q + CW'(1);
      end else if (rd_go) begin
        rd_ptr_q   <= rd_ptr_q + AW'(1);
        stor_cnt_q <= stor_cnt_q - CW'(1);
      end
    end
  end

  // Output slot: capture in RD_WAIT (slot is always empty then), clear on pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (state_q == RD_WAIT) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sram_rdata;
    end else if (out_valid_q && io.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign full         = (stor_cnt_q == CW'(DEPTH));
  assign count        = stor_cnt_q + CW'(state_q == RD_WAIT) + CW'(out_valid_q);
  assign empty        = (count == '0);
  assign io.in_ready  = in_ready_c;
  assign io.out_valid = out_valid_q;
  assign io.out_data  = out_data_q;

`ifdef SRAM_FIFO_WMARK_EN
  // High-water mark of total occupancy since reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak <= '0;
    end else if (count > peak) begin
      peak <= count;
    end
  end
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl driving a real sram model.
module tb_sram_fifo_ctrl;
  import sram_fifo_pkg::*;

  logic                  clk;
  logic                  rst_n;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  empty;
  logic [AW_DEFAULT-1:0] sram_addr;
  logic                  sram_we;
  logic [DW_DEFAULT-1:0] sram_wdata;
  logic [DW_DEFAULT-1:0] sram_rdata;
`ifdef SRAM_FIFO_WMARK_EN
  logic [CNT_W-1:0]      peak;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int we_viol  = 0;
  int rw_clash = 0;

  sram_fifo_ctrl_if #(.DW(DW_DEFAULT)) io ();

  sram_fifo_ctrl u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .io         (io),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .sram_addr  (sram_addr),
    .sram_we    (sram_we),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
`ifdef SRAM_FIFO_WMARK_EN
    ,
    .peak       (peak)
`endif
  );

  sram #(.DW(DW_DEFAULT), .AW(AW_DEFAULT)) u_sram (
    .clk      (clk),
    .addr     (sram_addr),
    .we       (sram_we),
    .data_in  (sram_wdata),
    .data_out (sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // SRAM writes only on accepted pushes; a read issue (!in_ready && !full) never writes
  always @(posedge clk) begin
    if (rst_n) begin
      if (sram_we !== (io.in_valid && io.in_ready)) we_viol++;
      if (!io.in_ready && !full && sram_we) rw_clash++;
    end
  end

  // Called just after a negedge; returns at the negedge after acceptance
  task automatic push(input logic [3:0] d);
    bit done;
    done = 1'b0;
    io.in_valid = 1'b1;
    io.in_data  = d;
    for (int i = 0; i < 20 && !done; i++) begin
      if (io.in_ready) done = 1'b1;
      @(negedge clk);
    end
    io.in_valid = 1'b0;
    if (!done) check("push_timeout", 32'(0), 32'(1));
  endtask

  // Called just after a negedge; returns at the negedge after the pop
  task automatic pop(input logic [3:0] exp);
    bit done;
    done = 1'b0;
    io.out_ready = 1'b1;
    for (int i = 0; i < 30 && !done; i++) begin
      if (io.out_valid) begin
        check("pop_data", 32'(io.out_data), 32'(exp));
        done = 1'b1;
      end
      @(negedge clk);
    end
    io.out_ready = 1'b0;
    if (!done) check("pop_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    logic [3:0] exp_d;
    rst_n        = 1'b0;
    io.in_valid  = 1'b0;
    io.in_data   = '0;
    io.out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_out_valid", 32'(io.out_valid), 32'(0));
    check("rst_out_data",  32'(io.out_data),  32'(0));
    check("rst_count",     32'(count),        32'(0));
    check("rst_full",      32'(full),         32'(0));
    check("rst_empty",     32'(empty),        32'(1));
    check("rst_sram_we",   32'(sram_we),      32'(0));
    check("rst_sram_addr", 32'(sram_addr),    32'(0));
`ifdef SRAM_FIFO_WMARK_EN
    check("rst_peak",      32'(peak),         32'(0));
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Scenario 1: single word latency
    io.in_valid  = 1'b1;
    io.in_data   = 4'hA;
    io.out_ready = 1'b1;
    check("s1_in_ready", 32'(io.in_ready), 32'(1));
    check("s1_wdata",    32'(sram_wdata),  32'hA);
    @(negedge clk);
    io.in_valid = 1'b0;
    check("s1_t1_count",    32'(count),        32'(1));
    check("s1_t1_rdgo_rdy", 32'(io.in_ready),  32'(0));
    check("s1_t1_addr",     32'(sram_addr),    32'(0));
    check("s1_t1_valid",    32'(io.out_valid), 32'(0));
    @(negedge clk);
    check("s1_t2_valid",    32'(io.out_valid), 32'(0));
    check("s1_t2_count",    32'(count),        32'(1));
    @(negedge clk);
    check("s1_t3_valid",    32'(io.out_valid), 32'(1));
    check("s1_t3_data",     32'(io.out_data),  32'hA);
    check("s1_t3_count",    32'(count),        32'(1));
    @(negedge clk);
    io.out_ready = 1'b0;
    check("s1_popped_valid", 32'(io.out_valid), 32'(0));
    check("s1_popped_count", 32'(count),        32'(0));
    check("s1_popped_empty", 32'(empty),        32'(1));

    // Scenario 2: fill to DEPTH+1 with consumer stalled
    for (int k = 1; k <= 5; k++) push(4'(k));
    check("s2_full",     32'(full),         32'(1));
    check("s2_count",    32'(count),        32'(5));
    check("s2_in_ready", 32'(io.in_ready),  32'(0));
    check("s2_valid",    32'(io.out_valid), 32'(1));
    check("s2_head",     32'(io.out_data),  32'h1);
    io.in_valid = 1'b1;
    io.in_data  = 4'hF;
    for (int k = 0; k < 3; k++) begin
      check("s2_stall_ready", 32'(io.in_ready), 32'(0));
      check("s2_stall_we",    32'(sram_we),     32'(0));
      @(negedge clk);
    end
    io.in_valid = 1'b0;
    check("s2_stall_count", 32'(count), 32'(5));

    // Scenario 3: drain in order
    for (int k = 1; k <= 5; k++) pop(4'(k));
    check("s3_empty", 32'(empty), 32'(1));
    check("s3_count", 32'(count), 32'(0));
    check("s3_full",  32'(full),  32'(0));
`ifdef SRAM_FIFO_WMARK_EN
    check("s3_peak",  32'(peak),  32'(5));
`endif

    // Scenario 4: interleaved push/pop across pointer wrap
    exp_d = 4'h0;
    for (int k = 0; k < 8; k++) begin
      push(4'(k));
      if (k % 2 == 1) begin
        pop(exp_d);
        exp_d = exp_d + 4'h1;
        pop(exp_d);
        exp_d = exp_d + 4'h1;
      end
    end
    check("s4_empty", 32'(empty), 32'(1));

    // Scenario 5: reset during RD_WAIT
    push(4'h5);
    @(negedge clk);
    check("s5_pre_count", 32'(count),        32'(1));
    check("s5_pre_valid", 32'(io.out_valid), 32'(0));
    rst_n = 1'b0;
    #1;
    check("s5_rst_count", 32'(count),        32'(0));
    check("s5_rst_empty", 32'(empty),        32'(1));
    check("s5_rst_valid", 32'(io.out_valid), 32'(0));
    check("s5_rst_we",    32'(sram_we),      32'(0));
    check("s5_rst_addr",  32'(sram_addr),    32'(0));
    @(negedge clk);
    check("s5_rst_hold_valid", 32'(io.out_valid), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);
    push(4'hC);
    pop(4'hC);
    check("s5_final_empty", 32'(empty), 32'(1));

    check("we_protocol",   32'(we_viol),  32'(0));
    check("rd_wr_clash",   32'(rw_clash), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
- Single-port FIFO controller that sits directly upstream of the 4x4 synchronous SRAM (`sram`).
- Accepts a valid/ready write stream and drives `sram` addr/we/data_in. Captures `sram` data_out into a one-entry output register and presents a valid/ready read stream.
- Turns the bare SRAM into a 4-deep (+1 output slot) FIFO.
- Respects the SRAM contract: one op per cycle (we=1 write, we=0 read), registered read data valid the cycle after the read.

Parameters:
- DW, 4, data width; matches SRAM word.
- AW, 2, SRAM address width.
- DEPTH, 1<<AW, SRAM entries (derived; not overridable).

Ports:
- clk  in  1  rising-edge clock, shared with sram.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  write request.
- in_data  in  DW  write data.
- in_ready  out  1  write accepted when in_valid&&in_ready.
- out_valid  out  1  output register holds data.
- out_data  out  DW  FIFO head.
- out_ready  in  1  consumer takes head when out_valid&&out_ready.
- count  out  AW+1  total occupancy (SRAM entries + in-flight read + output slot), 0..DEPTH+1.
- full  out  1  SRAM storage holds DEPTH entries.
- empty  out  1  count==0.
- sram_addr  out  AW  to sram addr.
- sram_we  out  1  to sram we.
- sram_wdata  out  DW  to sram data_in.
- sram_rdata  in  DW  from sram data_out.

Behaviour:
- Reset (async, rst_n=0):
  - wr_ptr=rd_ptr=0, stor_cnt=0, state=IDLE.
  - out_valid=0, out_data=0, count=0, full=0, empty=1.
  - sram_we=0, sram_addr=0.
  - Reset mid-operation discards all contents, including an in-flight read.
- States:
  - IDLE: no read outstanding.
  - RD_WAIT: read issued last cycle; sram_rdata is valid this cycle.
- Read issue (rd_go):
  - Condition: state==IDLE && stor_cnt!=0 && !out_valid.
  - Action: sram_we=0, sram_addr=rd_ptr; rd_ptr+1 mod DEPTH; stor_cnt-1; next state RD_WAIT.
- RD_WAIT:
  - out_data<=sram_rdata, out_valid<=1, next state IDLE, unconditionally.
  - Writes are allowed in this cycle (captured data is already registered in sram).
- Write:
  - in_ready = !full && !rd_go; combinational, no dependence on out_ready.
  - On accept: sram_we=1, sram_addr=wr_ptr, sram_wdata=in_data; wr_ptr+1 mod DEPTH; stor_cnt+1.
- Idle cycles: sram_we=0, sram_addr=rd_ptr; read result ignored.
- Read has priority over write; SRAM write and read never occur in the same cycle.
- Output pop: out_valid&&out_ready clears out_valid next cycle. The next read issues no earlier than that cycle.
- Steady-state drain rate: 1 word per 3 cycles.
- Latency: write accepted at cycle t into an empty FIFO:
  - rd_go at t+1;
  - out_valid at t+3 (captured at end of t+2).
- Counts and flags:
  - count = stor_cnt + (state==RD_WAIT) + out_valid.
  - full = (stor_cnt==DEPTH).
  - empty = (count==0).
- Boundaries:
  - Pointers wrap 3->0.
  - full deasserts in_ready even if a read issues that cycle.
  - in_valid while !in_ready holds; no data loss, no sram write.
  - out_ready while !out_valid is ignored.

Optional Feature:
- SRAM_FIFO_WMARK_EN defined: adds output peak  out  AW+1.
  - Registered maximum of count since reset.
  - Reset to 0; updates on the cycle after count exceeds it.
- Undefined: port and logic absent; no other behaviour changes.

Decomposition:
- Package sram_fifo_pkg:
  - DW/AW defaults.
  - state_t enum {IDLE, RD_WAIT}.
  - CNT_W=AW+1 constant.
- No sub-module: pointer/count logic and output register stay in one file.
- sram is instantiated alongside this block at the next level up; the bench instantiates both.

Test Plan:
1. Reset, then push 4'hA with out_ready=1 -> out_valid=1 with out_data=4'hA exactly 3 cycles after accept; count returns to 0.
2. Push 4'h1..4'h5 with out_ready=0:
   - 4'h1 moves to the output slot; 4'h2..4'h5 fill the SRAM.
   - Sixth push stalls (in_ready=0, full=1, count=5).
3. From scenario 2, assert out_ready=1 -> pops in order 1,2,3,4,5; empty=1 after the last pop.
4. Push 8 words 4'h0..4'h7 interleaved with pops -> output order 0..7 across pointer wrap; no sram write coincides with a read issue.
5. Assert rst_n=0 during RD_WAIT -> outputs return to reset values immediately; a post-reset push of 4'hC emerges as the first output.
6. With SRAM_FIFO_WMARK_EN defined, run scenario 2 then drain -> peak=5 persists after drain; without the macro, the build has no peak port.
